// File: rtl/abc_pkg.sv
// abc_pkg: shared FSM states, mode encodings and pattern count for abc_seq
package abc_pkg;
  localparam int N_PAT = 8;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  typedef enum logic [1:0] {M_UP = 2'b00, M_DOWN = 2'b01, M_GRAY = 2'b10, M_RSVD = 2'b11} mode_t;
endpackage

// File: rtl/bin2gray3.sv
// bin2gray3: combinational 3-bit binary to Gray conversion
module bin2gray3 (
  input  logic [2:0] bin,
  output logic [2:0] gray
);
  assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/abc_seq.sv
// abc_seq: handshaked 3-bit pattern sequencer (up/down/Gray) feeding a 3-to-8 decoder stage
module abc_seq import abc_pkg::*; #(
  parameter int SWEEP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic               cont,
  input  logic               load,
  input  logic [2:0]         seed,
  input  logic               rdy,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               vld,
  output logic               busy,
  output logic               done,
  output logic [SWEEP_W-1:0] sweeps
);
  state_t state, state_n;
  mode_t mode_q, mode_n;
  logic cont_q, cont_n, xfer, wrap;
  logic [2:0] idx, idx_n, step, step_n, start_idx, start_n, gray_n;
  logic [SWEEP_W-1:0] sweeps_n;
  bin2gray3 u_gray (.bin(idx_n), .gray(gray_n));
  always_comb begin
    xfer = state == RUN && rdy;
    wrap = xfer && step == 3'(N_PAT - 1);
    state_n = state;
    mode_n = mode_q;
    cont_n = cont_q;
    idx_n = idx;
    step_n = step;
    start_n = start_idx;
    sweeps_n = sweeps;
    if (state == IDLE) begin
      start_n = load ? seed : start_idx;
      if (start) begin
        state_n = RUN;
        idx_n = load ? seed : start_idx;
        mode_n = mode_t'(mode) == M_RSVD ? M_UP : mode_t'(mode);
        cont_n = cont;
        step_n = '0;
      end
    end
    if (xfer) begin
      idx_n = mode_q == M_DOWN ? idx - 3'd1 : idx + 3'd1;
      step_n = step + 3'd1;
    end
    if (wrap) begin
      sweeps_n = &sweeps ? sweeps : sweeps + 1'b1;
      state_n = cont_q ? RUN : FIN;
    end
    if (state == FIN || (state == RUN && abort)) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mode_q <= M_UP;
      cont_q <= 1'b0;
      idx <= '0;
      step <= '0;
      start_idx <= '0;
      sweeps <= '0;
      {a, b, c} <= 3'd0;
      vld <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      mode_q <= mode_n;
      cont_q <= cont_n;
      idx <= idx_n;
      step <= step_n;
      start_idx <= start_n;
      sweeps <= sweeps_n;
      {a, b, c} <= state_n == RUN ? (mode_n == M_GRAY ? gray_n : idx_n) : 3'd0;
      vld <= state_n == RUN;
      busy <= state_n != IDLE;
      done <= state_n == FIN;
    end
  end
endmodule

// File: tb/tb_abc_seq.sv
// tb_abc_seq: randomized self-checking bench for abc_seq against a transfer-count reference model
module tb_abc_seq;
  logic clk = 1'b0, rst, start, abort, cont, load, rdy, a, b, c, vld, busy, done;
  logic [1:0] mode;
  logic [2:0] seed;
  logic [3:0] sweeps;
  int errors = 0, checks = 0, sw_exp = 0;
  always #5 clk = ~clk;
  abc_seq #(.SWEEP_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .cont(cont),
    .load(load), .seed(seed), .rdy(rdy), .a(a), .b(b), .c(c), .vld(vld),
    .busy(busy), .done(done), .sweeps(sweeps)
  );
  function automatic logic [2:0] exp_pat(input int s, input int m, input int k);
    int i;
    i = m == 1 ? (((s - k) % 8) + 8) % 8 : (s + k) % 8;
    return m == 2 ? 3'(i ^ (i >> 1)) : 3'(i);
  endfunction
  function automatic int sat(input int v);
    return v > 15 ? 15 : v;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic begin_seq(input logic [2:0] s, input logic [1:0] m, input logic cn);
    load = 1'b1; seed = s; mode = m; cont = cn; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; start = 1'b1; abort = 1'b0; load = 1'b1; seed = 3'd6; mode = 2'd0; cont = 1'b0; rdy = 1'b1;
    tick(); tick();
    checks++;
    if ({a, b, c, vld, busy, done} !== 6'd0 || sweeps !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: got abc=%0d vld=%0b busy=%0b done=%0b sweeps=%0d, expected all 0", {a, b, c}, vld, busy, done, sweeps);
    end
    rst = 1'b0; start = 1'b0; load = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || vld !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%0b vld=%0b expected 0 0", busy, vld); end
  endtask
  task automatic test_up_single();
    seed = 3'd0; mode = 2'd0; cont = 1'b0; rdy = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (vld !== 1'b1 || {a, b, c} !== exp_pat(0, 0, k) || done !== 1'b0) begin
        errors++; $display("FAIL up_pat[%0d]: got vld=%0b abc=%0d done=%0b expected 1 %0d 0", k, vld, {a, b, c}, done, exp_pat(0, 0, k));
      end
      tick();
    end
    sw_exp = sat(sw_exp + 1);
    checks++;
    if (done !== 1'b1 || vld !== 1'b0 || busy !== 1'b1 || sweeps !== 4'(sw_exp)) begin
      errors++; $display("FAIL up_fin: done=%0b vld=%0b busy=%0b sweeps=%0d expected 1 0 1 %0d", done, vld, busy, sweeps, sw_exp);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL up_idle: done=%0b busy=%0b expected 0 0", done, busy); end
  endtask
  task automatic test_down_seed();
    load = 1'b1; seed = 3'd5;
    tick();
    load = 1'b0; seed = 3'd0; mode = 2'd1; cont = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (vld !== 1'b1 || {a, b, c} !== exp_pat(5, 1, k)) begin
        errors++; $display("FAIL down_pat[%0d]: got vld=%0b abc=%0d expected 1 %0d", k, vld, {a, b, c}, exp_pat(5, 1, k));
      end
      tick();
    end
    sw_exp = sat(sw_exp + 1);
    checks++;
    if (done !== 1'b1 || sweeps !== 4'(sw_exp)) begin errors++; $display("FAIL down_done: done=%0b sweeps=%0d expected 1 %0d", done, sweeps, sw_exp); end
    tick();
  endtask
  task automatic test_gray_cont();
    begin_seq(3'd0, 2'd2, 1'b1);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (vld !== 1'b1 || done !== 1'b0 || {a, b, c} !== exp_pat(0, 2, k)) begin
        errors++; $display("FAIL gray_pat[%0d]: got vld=%0b done=%0b abc=%0d expected 1 0 %0d", k, vld, done, {a, b, c}, exp_pat(0, 2, k));
      end
      if (k == 16) begin
        checks++;
        if (sweeps !== 4'(sat(sw_exp + 2))) begin errors++; $display("FAIL gray_sweeps: got %0d expected %0d", sweeps, sat(sw_exp + 2)); end
      end
      tick();
    end
    sw_exp = sat(sw_exp + 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL gray_abort: vld=%0b busy=%0b done=%0b expected 0 0 0", vld, busy, done); end
  endtask
  task automatic test_stall();
    begin_seq(3'd0, 2'd0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (vld !== 1'b1 || {a, b, c} !== exp_pat(0, 0, k)) begin
        errors++; $display("FAIL stall_pat[%0d]: got vld=%0b abc=%0d expected 1 %0d", k, vld, {a, b, c}, exp_pat(0, 0, k));
      end
      if (k == 3) begin
        rdy = 1'b0;
        for (int h = 0; h < 3; h++) begin
          tick();
          checks++;
          if (vld !== 1'b1 || {a, b, c} !== 3'd3) begin errors++; $display("FAIL stall_hold[%0d]: got vld=%0b abc=%0d expected 1 3", h, vld, {a, b, c}); end
        end
        rdy = 1'b1;
      end
      tick();
    end
    sw_exp = sat(sw_exp + 1);
    checks++;
    if (done !== 1'b1 || sweeps !== 4'(sw_exp)) begin errors++; $display("FAIL stall_done: done=%0b sweeps=%0d expected 1 %0d", done, sweeps, sw_exp); end
    tick();
  endtask
  task automatic test_abort();
    begin_seq(3'd0, 2'd0, 1'b0);
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if ({a, b, c} !== 3'd3) begin errors++; $display("FAIL abort_pre: got abc=%0d expected 3", {a, b, c}); end
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    checks++;
    if (vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sweeps !== 4'(sw_exp)) begin
      errors++; $display("FAIL abort_idle: vld=%0b busy=%0b done=%0b sweeps=%0d expected 0 0 0 %0d", vld, busy, done, sweeps, sw_exp);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (done !== 1'b0 || vld !== 1'b0) begin errors++; $display("FAIL abort_quiet[%0d]: done=%0b vld=%0b expected 0 0", k, done, vld); end
    end
  endtask
  task automatic test_reset_mid();
    begin_seq(3'd3, 2'd1, 1'b0);
    tick(); tick();
    rdy = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({a, b, c, vld, busy, done} !== 6'd0 || sweeps !== 4'd0) begin
      errors++; $display("FAIL midrst_outputs: abc=%0d vld=%0b busy=%0b done=%0b sweeps=%0d expected all 0", {a, b, c}, vld, busy, done, sweeps);
    end
    rst = 1'b0; rdy = 1'b1; sw_exp = 0;
    mode = 2'd0; cont = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (vld !== 1'b1 || {a, b, c} !== 3'd0) begin errors++; $display("FAIL midrst_restart: vld=%0b abc=%0d expected 1 0", vld, {a, b, c}); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask
  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int s, m, k, budget;
      s = $urandom_range(7); m = $urandom_range(3); k = 0; budget = 0;
      begin_seq(3'(s), 2'(m), 1'b0);
      while (k < 8 && budget < 200) begin
        checks++;
        if (vld !== 1'b1 || {a, b, c} !== exp_pat(s, m, k)) begin
          errors++; $display("FAIL rand_pat[%0d.%0d]: got vld=%0b abc=%0d expected 1 %0d", r, k, vld, {a, b, c}, exp_pat(s, m, k));
        end
        rdy = 1'($urandom_range(1));
        tick();
        if (rdy) k++;
        budget++;
      end
      rdy = 1'b1;
      sw_exp = sat(sw_exp + 1);
      checks++;
      if (k < 8 || done !== 1'b1 || vld !== 1'b0 || sweeps !== 4'(sw_exp)) begin
        errors++; $display("FAIL rand_done[%0d]: k=%0d done=%0b vld=%0b sweeps=%0d expected 8 1 0 %0d", r, k, done, vld, sweeps, sw_exp);
      end
      tick();
    end
  endtask
  initial begin
    test_reset();
    test_up_single();
    test_down_seed();
    test_gray_cont();
    test_stall();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/abc_seq.md
ABC_SEQ -- requirements
Module: abc_seq

Interface
REQ-001 The block SHALL have parameter SWEEP_W, default 4, giving the width of the completed-sweep counter.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL change on its rising edge only.
REQ-003 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, which begins a sequence when sampled high in IDLE.
REQ-005 The block SHALL have port abort, input, 1 bit, which terminates a running sequence.
REQ-006 The block SHALL have port mode, input, 2 bits: 00 binary up, 01 binary down, 10 Gray up, 11 reserved (treated as 00).
REQ-007 The block SHALL have port cont, input, 1 bit: 1 wraps continuously, 0 runs a single sweep.
REQ-008 The block SHALL have ports load, input, 1 bit, and seed, input, 3 bits, which set the start index.
REQ-009 The block SHALL have port rdy, input, 1 bit, the downstream decoder-stage ready.
REQ-010 The block SHALL have ports a, b and c, outputs, 1 bit each, with a as MSB; these are the pattern presented to the 3-to-8 decoder stage.
REQ-011 The block SHALL have port vld, output, 1 bit, marking a, b and c as valid.
REQ-012 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-013 The block SHALL have port done, output, 1 bit, a one-cycle pulse at the end of a single sweep.
REQ-014 The block SHALL have port sweeps, output, SWEEP_W bits, counting completed sweeps; it SHALL saturate at its maximum.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and FIN.
REQ-016 In IDLE, load=1 SHALL write seed into the start-index register one cycle later; load outside IDLE SHALL be ignored.
REQ-017 In IDLE, start=1 SHALL move the FSM to RUN on the next edge, load idx with the start index, latch mode and cont, clear the step counter and assert vld.
REQ-018 If load and start are high in the same IDLE cycle, seed SHALL be used as the start index.
REQ-019 The outputs {a,b,c} SHALL equal idx for modes up and down, and idx^(idx>>1) for Gray mode.
REQ-020 Each handshake transfer SHALL occur on a cycle with vld=1 and rdy=1.
REQ-021 When vld=1 and rdy=0, a, b, c and vld SHALL hold stable.
REQ-022 On each transfer, idx SHALL advance modulo 8: +1 for up and Gray, -1 for down (7 to 0 wrap for up/Gray, 0 to 7 wrap for down).
REQ-023 Each transfer SHALL increment the 3-bit step counter.
REQ-024 When the 8th transfer of a sweep occurs, sweeps SHALL increment (saturating) on the same edge, and the step counter SHALL wrap to 0.
REQ-025 On the 8th transfer with cont=1, the block SHALL remain in RUN with vld=1, so that the next pattern equals the first pattern of the sweep.
REQ-026 On the 8th transfer with cont=0, the FSM SHALL go to FIN and vld SHALL fall on that edge.
REQ-027 FIN SHALL last exactly one cycle, with done=1, and then return to IDLE.
REQ-028 abort=1 in RUN SHALL force IDLE on the next edge, drop vld and suppress done; sweeps SHALL be unchanged unless that same cycle completed a sweep.
REQ-029 abort SHALL take priority over start and over transfer-driven transitions.
REQ-030 start seen in RUN or FIN SHALL be ignored.
REQ-031 The latency from start to the first vld SHALL be exactly one cycle.
REQ-032 With rdy held high, one pattern SHALL be emitted per cycle; a single sweep SHALL take 8 cycles plus 1 FIN cycle.

Reset
REQ-033 On rst=1 at a clock edge, the FSM SHALL enter IDLE, and a, b, c, vld, busy and done SHALL be 0.
REQ-034 On rst=1 at a clock edge, sweeps, idx, the step counter and the start index SHALL be 0, and the latched mode SHALL be up.
REQ-035 rst SHALL take priority over all other inputs, including a reset asserted mid-sweep or while stalled.

Structure
REQ-036 The FSM state encoding, the mode encodings and the pattern count 8 SHALL reside in the shared package abc_pkg.
REQ-037 The Gray conversion SHALL be implemented in the sub-module bin2gray3, which is purely combinational.
REQ-038 All outputs SHALL be registered.

Verification
REQ-039 The bench SHALL apply: reset, seed=0, mode=00, cont=0, rdy=1, start pulse; required response: patterns 0..7 on consecutive cycles, done high in the cycle after pattern 7, sweeps=1, busy low after FIN.
REQ-040 The bench SHALL apply: mode=01, load with seed=5, start; required response: patterns 5,4,3,2,1,0,7,6 in that order, then done.
REQ-041 The bench SHALL apply: mode=10, cont=1, run for 20 transfers; required response: patterns 0,1,3,2,6,7,5,4 repeated, no done, sweeps=2 after the 16th transfer.
REQ-042 The bench SHALL drop rdy for 3 cycles while pattern 3 is shown; required response: a, b, c and vld hold pattern 3 and there is no skip or repeat after rdy returns.
REQ-043 The bench SHALL assert abort and start together on the 4th transfer; required response: IDLE next cycle, vld=0, done never asserted, sweeps unchanged.
REQ-044 The bench SHALL assert rst mid-sweep with rdy=0; required response: all outputs 0 on the next edge, and a subsequent start begins from 0.
